// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
//
// Binary-to-one-hot decoder. An IN_W-bit select index drives exactly one of
// OUT_W = 2**IN_W lines to the active level. Two views of the decode are
// provided: a purely combinational one and a copy registered on the rising
// clock edge, accompanied by a valid flag that records whether the enable was
// high in the sampled cycle.
//
// Parameters
//   IN_W    : width of the select index (legal range 1..6)
//   OUT_W   : number of output lines, always 2**IN_W (leave at default)
//   ACT_LOW : 1 inverts both outputs so the selected line is low and the
//             idle level is all-ones
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   en      : decode enable, 0 forces every line inactive
//   a       : binary select index
//   y_comb  : combinational one-hot decode of a
//   y       : registered decode, one cycle behind y_comb
//   y_vld   : y holds a decode taken from a cycle where en was 1
// -----------------------------------------------------------------------------
module decoder_3to8 #(
   parameter int IN_W    = 3,
   parameter int OUT_W   = 2 ** IN_W,
   parameter bit ACT_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IN_W-1:0]  a,
   output logic [OUT_W-1:0] y_comb,
   output logic [OUT_W-1:0] y,
   output logic             y_vld
);

   // Level every line sits at when nothing is selected.
   localparam logic [OUT_W-1:0] Y_IDLE = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   logic [OUT_W-1:0] one_hot;
   logic             hit;

   // Active-high one-hot decode. Each line compares the index against its
   // own position; when no line matches (only possible when a carries X/Z in
   // simulation) the whole vector goes to X so an unknown index can never
   // look like a legal selection. Synthesis treats that branch as a
   // don't-care because a known index always hits exactly one line.
   always_comb begin
      one_hot = '0;
      hit     = 1'b0;
      if (en) begin
         for (int i = 0; i < OUT_W; i++) begin
            case (a)
               IN_W'(i): begin
                  one_hot[i] = 1'b1;
                  hit        = 1'b1;
               end
               default: ;
            endcase
         end
         if (!hit) begin
            one_hot = 'x;
         end
      end
   end

   // Polarity is applied once here so the registered copy inherits it.
   assign y_comb = ACT_LOW ? ~one_hot : one_hot;

   // One-cycle registered copy of the decode. There is no hold: a cycle with
   // en low produces an idle y and a cleared y_vld on the following edge.
   // Reset drops both immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= Y_IDLE;
         y_vld <= 1'b0;
      end else begin
         y     <= y_comb;
         y_vld <= en;
      end
   end

endmodule

// File: tb/tb_decoder_3to8.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8
//
// Drives an active-high and an active-low decoder from the same inputs.
// A reference model derives the expected outputs arithmetically (a shifted
// one for the selected line, delayed by one edge for the registered view)
// and is compared against both instances on every falling clock edge.
// Directed steps additionally check hand-written literal patterns.
// -----------------------------------------------------------------------------
module tb_decoder_3to8;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] a;

   logic [7:0] y_comb;
   logic [7:0] y;
   logic       y_vld;
   logic [7:0] y_comb_n;
   logic [7:0] y_n;
   logic       y_vld_n;

   int checks = 0;
   int errors = 0;

   logic [7:0] one_hot_tbl [8] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                                   8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};

   logic [7:0] m_comb;
   logic [7:0] m_y;
   logic       m_vld;

   decoder_3to8 #(.IN_W(3), .ACT_LOW(1'b0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .a      (a),
      .y_comb (y_comb),
      .y      (y),
      .y_vld  (y_vld)
   );

   decoder_3to8 #(.IN_W(3), .ACT_LOW(1'b1)) dut_n (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .a      (a),
      .y_comb (y_comb_n),
      .y      (y_n),
      .y_vld  (y_vld_n)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode: the selected line is 1 shifted left by the index.
   always_comb begin
      m_comb = en ? (8'd1 << a) : 8'd0;
   end

   // Reference registered view: last sampled decode, cleared at once by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_y   <= 8'd0;
         m_vld <= 1'b0;
      end else begin
         m_y   <= m_comb;
         m_vld <= en;
      end
   end

   // Single comparison point shared by every check in the bench.
   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 2 time units after a rising edge, clear of both edges.
   task automatic applyStimulus(input logic r, input logic e, input logic [2:0] v);
      @(posedge clk);
      #2;
      rst_n = r;
      en    = e;
      a     = v;
   endtask

   // Model comparison on every falling edge for both polarities.
   always @(negedge clk) begin
      checkOutput("model_y_comb",   y_comb,          m_comb);
      checkOutput("model_y",        y,               m_y);
      checkOutput("model_y_vld",    {7'd0, y_vld},   {7'd0, m_vld});
      checkOutput("model_y_comb_n", y_comb_n,        ~m_comb);
      checkOutput("model_y_n",      y_n,             ~m_y);
      checkOutput("model_y_vld_n",  {7'd0, y_vld_n}, {7'd0, m_vld});
   end

   // Watchdog so the run always ends even if the stimulus stalls.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence with literal expectations.
   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      a     = 3'b101;

      // Held in reset while clocking: registers stay idle, comb follows a.
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_y_comb",   y_comb,        8'b00100000);
      checkOutput("rst_y",        y,             8'b00000000);
      checkOutput("rst_y_vld",    {7'd0, y_vld}, 8'd0);
      checkOutput("rst_y_n",      y_n,           8'b11111111);
      checkOutput("rst_y_comb_n", y_comb_n,      8'b11011111);

      // Release, then sweep every index.
      applyStimulus(1'b1, 1'b1, 3'b101);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, 3'(i));
         #1;
         checkOutput("sweep_y_comb", y_comb, one_hot_tbl[i]);
         if (i == 0) begin
            checkOutput("sweep_y_first", y, 8'b00100000);
         end else begin
            checkOutput("sweep_y", y, one_hot_tbl[i-1]);
         end
         checkOutput("sweep_y_vld", {7'd0, y_vld}, 8'd1);
      end

      // Enable gating on index 6.
      applyStimulus(1'b1, 1'b1, 3'b110);
      #1;
      checkOutput("gate_comb_on", y_comb, 8'b01000000);
      applyStimulus(1'b1, 1'b0, 3'b110);
      #1;
      checkOutput("gate_comb_off", y_comb, 8'b00000000);
      checkOutput("gate_y_on",     y,      8'b01000000);
      checkOutput("gate_vld_on",   {7'd0, y_vld}, 8'd1);
      applyStimulus(1'b1, 1'b1, 3'b110);
      #1;
      checkOutput("gate_comb_on2", y_comb, 8'b01000000);
      checkOutput("gate_y_off",    y,      8'b00000000);
      checkOutput("gate_vld_off",  {7'd0, y_vld}, 8'd0);
      checkOutput("gate_y_n_off",  y_n,    8'b11111111);
      applyStimulus(1'b1, 1'b1, 3'b110);
      #1;
      checkOutput("gate_y_on2",    y,      8'b01000000);
      checkOutput("gate_vld_on2",  {7'd0, y_vld}, 8'd1);

      // Asynchronous reset between edges.
      applyStimulus(1'b1, 1'b1, 3'b111);
      @(posedge clk);
      #2;
      checkOutput("async_pre_y", y, 8'b10000000);
      rst_n = 1'b0;
      #1;
      checkOutput("async_y",     y,             8'b00000000);
      checkOutput("async_y_vld", {7'd0, y_vld}, 8'd0);
      checkOutput("async_y_n",   y_n,           8'b11111111);
      applyStimulus(1'b1, 1'b1, 3'b111);
      @(posedge clk);
      #1;
      checkOutput("async_first_y",   y,             8'b10000000);
      checkOutput("async_first_vld", {7'd0, y_vld}, 8'd1);

      // Active-low instance.
      applyStimulus(1'b1, 1'b1, 3'b010);
      #1;
      checkOutput("actlow_comb", y_comb_n, 8'b11111011);
      applyStimulus(1'b1, 1'b0, 3'b010);
      #1;
      checkOutput("actlow_comb_off", y_comb_n, 8'b11111111);
      checkOutput("actlow_y",        y_n,      8'b11111011);
      checkOutput("actlow_vld",      {7'd0, y_vld_n}, 8'd1);

      // Unknown index: a four-state simulator must show all-X on y_comb.
      // A two-state simulator resolves the X to a known value instead, in
      // which case the decode of that value is checked.
      applyStimulus(1'b1, 1'b1, 3'bxxx);
      #1;
      if ($isunknown(a)) begin
         checkOutput("unknown_y_comb", y_comb, 8'bxxxxxxxx);
      end else begin
         checkOutput("unknown_resolved_y_comb", y_comb, one_hot_tbl[a]);
      end

      // Return to known inputs and let the model run a few more cycles.
      applyStimulus(1'b1, 1'b1, 3'b000);
      applyStimulus(1'b1, 1'b1, 3'b111);
      applyStimulus(1'b1, 1'b0, 3'b011);
      repeat (3) @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
